trng_health_reader: RTL
=======================

# trng_health_reader

Consumer side of the ring-oscillator entropy path. Samples the raw TRNG bit stream one strobe at a time and runs continuous SP 800-90B-style health tests (repetition count and adaptive proportion) on the raw bits. Packs accepted bits into bytes and hands them out over a valid/ready port. Latches an alarm and stops delivering data when either health test fails.

## Interface
Parameters:
- `RCT_CUTOFF`, 31: run length of identical raw bits that counts as a failure.
- `APT_WINDOW`, 512: adaptive-proportion window length, in raw bits.
- `APT_CUTOFF`, 410: count of the window's reference value that counts as a failure.
- `STARTUP_BITS`, 1024: raw bits that must be tested, with no failure, before any output is produced.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; low returns the block to IDLE (except from FAIL).
- `raw_bit`  in  1  raw entropy bit.
- `raw_valid`  in  1  one-cycle strobe qualifying `raw_bit`.
- `clear_alarm`  in  1  leaves FAIL and clears `overflow`.
- `rnd_byte`  out  8  packed random byte.
- `rnd_valid`  out  1  `rnd_byte` is valid.
- `rnd_ready`  in  1  consumer accepts `rnd_byte`.
- `alarm`  out  1  health-test failure latched.
- `state`  out  2  IDLE=0, STARTUP=1, RUN=2, FAIL=3.
- `overflow`  out  1  sticky; a completed byte was dropped.

## Operation
- Reset values: `state`=IDLE, every output 0, every counter 0, shift register and holding register empty.
- FSM:
  - IDLE: `enable`=1 goes to STARTUP.
  - STARTUP: health tests run and packed bits are discarded. After `STARTUP_BITS` raw bits with no failure, go to RUN.
  - RUN: health tests run and bits are packed.
  - A failure in STARTUP or RUN goes to FAIL.
  - FAIL: `alarm`=1. `raw_valid` is ignored. Holding register and shift register are flushed, so `rnd_valid`=0. `clear_alarm` goes to IDLE. `enable` is ignored while in FAIL.
  - `enable`=0 in STARTUP or RUN goes to IDLE and flushes all counters and registers.
  - If `clear_alarm` and a failure occur in the same cycle, the failure wins and the state stays FAIL.
- Repetition count test (RCT):
  - Counter holds the run length of identical raw bits; it resets to 1 when the bit changes.
  - Failure when the counter reaches `RCT_CUTOFF`.
  - The counter saturates at `RCT_CUTOFF`.
- Adaptive proportion test (APT):
  - The first bit of each window is the reference, and the count starts at 1.
  - Each further bit equal to the reference increments the count.
  - Failure when the count reaches `APT_CUTOFF` inside the window.
  - After `APT_WINDOW` bits, the next bit starts a new window.
- Health tests always operate on raw bits, before any conditioning.
- Packing:
  - Conditioned bits shift into an 8-bit register MSB-first, so the first bit ends up at `rnd_byte[7]`.
  - On the 8th bit, the byte moves to the holding register if the holding register is empty or is being popped (`rnd_valid & rnd_ready`) in the same cycle.
  - Otherwise the new byte is dropped and `overflow` is set.
- Handshake:
  - `rnd_byte` is stable while `rnd_valid`=1.
  - A pop occurs on any cycle with `rnd_valid & rnd_ready`.
  - `rnd_valid` does not depend combinationally on `rnd_ready`.
- Counter widths are `$clog2(param+1)`. The STARTUP counter stops at `STARTUP_BITS`.

## Timing
- Everything updates on the `clk` edge that samples `raw_valid`=1.
- Byte latency: `rnd_valid` goes high after the edge capturing the 8th conditioned bit (0 extra cycles). A simultaneous pop and refill keeps `rnd_valid`=1 with the new byte.
- Failure: `state`=FAIL and `alarm`=1 become visible after the edge that captured the failing bit. `rnd_valid` drops on that same edge.
- STARTUP to RUN: takes effect on the edge of raw bit number `STARTUP_BITS`. That bit is not packed; the first packed bit is bit `STARTUP_BITS`+1.
- `clear_alarm`: FAIL to IDLE on the next edge. `alarm` and `overflow` are 0 after that edge.
- Reset mid-operation: asynchronous; all outputs fall immediately, and any pending byte is lost.

## Configuration
- `TRNG_VN_DEBIAS_EN` defined: a Von Neumann corrector pairs consecutive raw bits.
  - 01 gives 0; 10 gives 1; 00 and 11 produce nothing.
  - The pair register clears on entry to STARTUP, RUN and IDLE.
- Undefined: every raw bit is forwarded to the packer unchanged.

## Structure
- Package `trng_pkg`: state enum (`TRNG_IDLE`, `TRNG_STARTUP`, `TRNG_RUN`, `TRNG_FAIL`) and default cutoff constants.
- Sub-module `trng_health_test`: holds RCT and APT. Inputs are `clk`, `rst_n`, `clr`, `bit_valid`, `bit_in`; output is a single-cycle `fail` pulse.
- The top level holds the FSM, the optional corrector, the packer and the holding register.

## Test plan
- Reset during RUN with `rnd_valid`=1: assert `rst_n`=0 → all outputs 0 and `state`=0 immediately, without a clock edge.
- Defaults, corrector off: 1024 alternating bits → `state`=2 on bit 1024. Next 8 bits 1,0,1,0,0,1,0,1 → `rnd_byte`=0xA5 and `rnd_valid`=1, held for 20 cycles with `rnd_ready`=0.
- In RUN, 31 consecutive 1s → `alarm`=1, `state`=3 after the 31st bit, `rnd_valid`=0. Then `clear_alarm` pulse → `state`=0, `alarm`=0.
- APT: 410 zeros in one 512-bit window, with no run ≥ 31 → `alarm` set exactly on the 410th zero. The same pattern with 409 zeros → no alarm.
- Backpressure: `rnd_ready`=0, 16 bits in RUN → first byte held intact, second byte dropped, `overflow`=1. Then `clear_alarm` → `overflow`=0 with the byte still valid.
- `TRNG_VN_DEBIAS_EN` defined: 32 pairs of 10,01,11,00 repeated, in RUN → 0xAA and 0xAA, bits emitted in the order 1,0,1,0….

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default health-test cutoffs for the TRNG reader path.
// Holds the FSM state encoding seen on the reader's state port.
package trng_pkg;

  typedef enum logic [1:0] {
    TRNG_IDLE    = 2'd0,
    TRNG_STARTUP = 2'd1,
    TRNG_RUN     = 2'd2,
    TRNG_FAIL    = 2'd3
  } trng_state_t;

  localparam int unsigned RCT_CUTOFF_DEF   = 31;
  localparam int unsigned APT_WINDOW_DEF   = 512;
  localparam int unsigned APT_CUTOFF_DEF   = 410;
  localparam int unsigned STARTUP_BITS_DEF = 1024;

endpackage

// File: rtl/trng_health_test.sv
// Repetition-count and adaptive-proportion tests on raw TRNG bits.
// Ports: clk, rst_n, clr (sync flush), bit_valid, bit_in -> fail (comb pulse).
module trng_health_test
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic fail
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW + 1);
  localparam int CW = $clog2(APT_CUTOFF + 1);

  logic [RW-1:0] rct_cnt;
  logic [RW-1:0] rct_nxt;
  logic          last_bit;
  logic [AW-1:0] apt_idx;
  logic [CW-1:0] apt_cnt;
  logic [CW-1:0] apt_nxt;
  logic          apt_ref;
  logic          new_win;

  // fail is judged on the incoming bit so the FSM
  // can react on the same edge that captures it
  always_comb begin
    rct_nxt = rct_cnt;
    apt_nxt = apt_cnt;
    new_win = (apt_idx == '0) ||
              (apt_idx == AW'(APT_WINDOW));
    if (rct_cnt == '0 || bit_in != last_bit)
      rct_nxt = RW'(1);
    else if (rct_cnt != RW'(RCT_CUTOFF))
      rct_nxt = rct_cnt + 1'b1;
    if (new_win)
      apt_nxt = CW'(1);
    else if (bit_in == apt_ref &&
             apt_cnt != CW'(APT_CUTOFF))
      apt_nxt = apt_cnt + 1'b1;
    fail = bit_valid &
           ((rct_nxt == RW'(RCT_CUTOFF)) |
            (apt_nxt == CW'(APT_CUTOFF)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt  <= '0;
      last_bit <= 1'b0;
      apt_idx  <= '0;
      apt_cnt  <= '0;
      apt_ref  <= 1'b0;
    end else if (clr) begin
      rct_cnt  <= '0;
      last_bit <= 1'b0;
      apt_idx  <= '0;
      apt_cnt  <= '0;
      apt_ref  <= 1'b0;
    end else if (bit_valid) begin
      rct_cnt  <= rct_nxt;
      last_bit <= bit_in;
      apt_cnt  <= apt_nxt;
      apt_idx  <= new_win ? AW'(1)
                          : apt_idx + 1'b1;
      if (new_win) apt_ref <= bit_in;
    end
  end

endmodule

// File: rtl/trng_health_reader.sv
// TRNG consumer: health tests, startup gating, byte packing, valid/ready out.
// Ports: clk, rst_n, enable, raw_bit/raw_valid, clear_alarm, rnd_byte/
// rnd_valid/rnd_ready, alarm, state, overflow. Macro TRNG_VN_DEBIAS_EN
// enables the Von Neumann corrector.
module trng_health_reader
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF   = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW   = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF   = APT_CUTOFF_DEF,
  parameter int unsigned STARTUP_BITS = STARTUP_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic       clear_alarm,
  output logic [7:0] rnd_byte,
  output logic       rnd_valid,
  input  logic       rnd_ready,
  output logic       alarm,
  output logic [1:0] state,
  output logic       overflow
);

  localparam int SW = $clog2(STARTUP_BITS + 1);

  trng_state_t st;
  logic [SW-1:0] su_cnt;
  logic          active;
  logic          bit_valid;
  logic          fail;
  logic          go_run;
  logic          cond_valid;
  logic          cond_bit;
  logic          pack_en;
  logic          pop;
  logic          flush;
  logic          byte_done;
  logic          drop;
  logic [6:0]    sr;
  logic [2:0]    sr_cnt;

  assign state  = st;
  assign active = enable &
                  (st == TRNG_STARTUP || st == TRNG_RUN);
  assign bit_valid = active & raw_valid;
  assign go_run = bit_valid & ~fail &
                  (st == TRNG_STARTUP) &
                  (su_cnt == SW'(STARTUP_BITS - 1));

  trng_health_test #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (~active),
    .bit_valid (bit_valid),
    .bit_in    (raw_bit),
    .fail      (fail)
  );

`ifdef TRNG_VN_DEBIAS_EN
  logic vn_have;
  logic vn_first;

  // 10 -> 1, 01 -> 0: the emitted bit is the pair's first bit
  assign cond_valid = bit_valid & vn_have &
                      (vn_first != raw_bit);
  assign cond_bit   = vn_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
    end else if (!active || go_run) begin
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
    end else if (bit_valid) begin
      vn_have  <= ~vn_have;
      vn_first <= raw_bit;
    end
  end
`else
  assign cond_valid = bit_valid;
  assign cond_bit   = raw_bit;
`endif

  assign pack_en   = cond_valid & (st == TRNG_RUN);
  assign pop       = rnd_valid & rnd_ready;
  assign flush     = ~active | fail;
  assign byte_done = pack_en & (sr_cnt == 3'd7);
  assign drop      = byte_done & ~flush &
                     rnd_valid & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= TRNG_IDLE;
      alarm  <= 1'b0;
      su_cnt <= '0;
    end else begin
      unique case (st)
        TRNG_IDLE:
          if (enable) st <= TRNG_STARTUP;
        TRNG_STARTUP, TRNG_RUN:
          if (!enable) begin
            st <= TRNG_IDLE;
          end else if (fail) begin
            st    <= TRNG_FAIL;
            alarm <= 1'b1;
          end else if (go_run) begin
            st <= TRNG_RUN;
          end
        TRNG_FAIL:
          if (clear_alarm) begin
            st    <= TRNG_IDLE;
            alarm <= 1'b0;
          end
      endcase
      if (!active)
        su_cnt <= '0;
      else if (bit_valid && !fail &&
               st == TRNG_STARTUP &&
               su_cnt != SW'(STARTUP_BITS))
        su_cnt <= su_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      sr_cnt    <= '0;
      rnd_byte  <= '0;
      rnd_valid <= 1'b0;
    end else if (flush) begin
      sr        <= '0;
      sr_cnt    <= '0;
      rnd_byte  <= '0;
      rnd_valid <= 1'b0;
    end else begin
      if (pop) rnd_valid <= 1'b0;
      if (pack_en) begin
        sr     <= {sr[5:0], cond_bit};
        sr_cnt <= sr_cnt + 1'b1;
      end
      if (byte_done && (!rnd_valid || pop)) begin
        rnd_byte  <= {sr, cond_bit};
        rnd_valid <= 1'b1;
      end
    end
  end

  // sticky; a drop in the same cycle as a clear is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (clear_alarm) overflow <= 1'b0;
  end

endmodule
